// File: rtl/cellrv32_xirq_rr.sv
// rtl/cellrv32_xirq_rr.sv - external interrupt controller, up to 32 lines, fixed/round-robin arbitration
module cellrv32_xirq_rr #(
  parameter int          NUM_CH      = 1,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TTYPE_RST   = 32'h0,
  parameter logic [31:0] TPOL_RST    = 32'h0,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF80
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic [31:0] xirq_i,
  output logic        cpu_irq_o
);

  generate
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("cellrv32_xirq_rr: NUM_CH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("cellrv32_xirq_rr: SYNC_STAGES must be 2..4");
    end
  endgenerate

  localparam logic [31:0] CH_MASK = 32'((64'd1 << NUM_CH) - 64'd1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [31:0] enable_q, pending_q, ttype_q, tpol_q;
  logic [1:0]  ctrl_q;
  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] line_d_q, trig_q;
  state_t      state_q, state_d;
  logic [4:0]  id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic        irq_q, irq_d;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic        acc_en, wr, rd, complete;
  logic [2:0]  reg_sel;
  logic [31:0] line, trig_c, clr_mask, pending_d, rdata_c;
  logic        sel_found;
  logic [4:0]  sel_id;
  logic [5:0]  base_c, idx_c;

  assign acc_en  = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign wr      = acc_en & wren_i;
  assign rd      = acc_en & rden_i;
  assign reg_sel = addr_i[4:2];

  // line_d_q extends the chain by one so edge and level triggers see the same latency
  assign line   = sync_q[SYNC_STAGES-1];
  assign trig_c = (ttype_q & ((tpol_q & line & ~line_d_q) | (~tpol_q & ~line & line_d_q)))
                | (~ttype_q & ~(line ^ tpol_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      line_d_q <= '0;
      trig_q   <= '0;
    end else begin
      sync_q[0] <= xirq_i & CH_MASK;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      line_d_q <= line;
      trig_q   <= trig_c & CH_MASK;
    end
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed mode
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    base_c    = ctrl_q[1] ? {1'b0, rr_ptr_q} : 6'd0;
    idx_c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_c = base_c + 6'(k);
      if (idx_c >= 6'(NUM_CH)) idx_c = idx_c - 6'(NUM_CH);
      if (!sel_found && pending_q[idx_c[4:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx_c[4:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    irq_d    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0] && sel_found) begin
          irq_d   = 1'b1;
          id_d    = sel_id;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (wr && reg_sel == 3'd2) begin
          complete = 1'b1;
          rr_ptr_d = (id_q == 5'(NUM_CH - 1)) ? 5'd0 : id_q + 5'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New triggers win over a same-cycle clear from W1C or complete
  always_comb begin
    clr_mask = '0;
    if (wr && reg_sel == 3'd1) clr_mask = data_i;
    if (complete) clr_mask = clr_mask | (32'd1 << id_q);
    pending_d = ((pending_q & ~clr_mask) | (trig_q & enable_q)) & CH_MASK;
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      3'd0:    rdata_c = enable_q;
      3'd1:    rdata_c = pending_q;
      3'd2:    rdata_c = {state_q == S_ACTIVE, 26'b0, id_q};
      3'd3:    rdata_c = ttype_q;
      3'd4:    rdata_c = tpol_q;
      3'd5:    rdata_c = {30'b0, ctrl_q};
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q  <= '0;
      pending_q <= '0;
      ttype_q   <= TTYPE_RST & CH_MASK;
      tpol_q    <= TPOL_RST & CH_MASK;
      ctrl_q    <= '0;
      state_q   <= S_IDLE;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      irq_q     <= irq_d;
      ack_q     <= acc_en & (rden_i | wren_i);
      rdata_q   <= rd ? rdata_c : '0;
      if (wr) begin
        case (reg_sel)
          3'd0:    enable_q <= data_i & CH_MASK;
          3'd3:    ttype_q  <= data_i & CH_MASK;
          3'd4:    tpol_q   <= data_i & CH_MASK;
          3'd5:    ctrl_q   <= data_i[1:0];
          default: ;
        endcase
      end
    end
  end

  assign data_o    = rdata_q;
  assign ack_o     = ack_q;
  assign cpu_irq_o = irq_q;

endmodule

// File: tb/tb_cellrv32_xirq_rr.sv
// tb/tb_cellrv32_xirq_rr.sv - scoreboard bench for cellrv32_xirq_rr
module tb_cellrv32_xirq_rr;

  localparam logic [31:0] BASE    = 32'hFFFFFF80;
  localparam logic [31:0] A_EN    = BASE + 32'd0;
  localparam logic [31:0] A_PEND  = BASE + 32'd4;
  localparam logic [31:0] A_SRC   = BASE + 32'd8;
  localparam logic [31:0] A_TTYPE = BASE + 32'd12;
  localparam logic [31:0] A_TPOL  = BASE + 32'd16;
  localparam logic [31:0] A_CTRL  = BASE + 32'd20;
  localparam logic [31:0] A_UNM   = BASE + 32'd28;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i, data_i, data_o, xirq_i;
  logic        rden_i, wren_i, ack_o, cpu_irq_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] v;
  int          cyc;

  cellrv32_xirq_rr #(
    .NUM_CH(8), .SYNC_STAGES(2), .TTYPE_RST(32'h123456A5),
    .TPOL_RST(32'hFFFFFF0F), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .rden_i(rden_i), .wren_i(wren_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .xirq_i(xirq_i), .cpu_irq_o(cpu_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; data_i = d; wren_i = 1'b1;
    @(negedge clk);
    wren_i = 1'b0; data_i = '0;
    check_eq("wr_ack", {31'b0, ack_o}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; rden_i = 1'b1;
    @(negedge clk);
    rden_i = 1'b0;
    check_eq("rd_ack", {31'b0, ack_o}, 32'd1);
    d = data_o;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_irq_o && n < 30);
    check_eq(tag, {31'b0, cpu_irq_o}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'b0, cpu_irq_o}, 32'd0);
  endtask

  // SOURCE can never read all-ones, so an empty scoreboard always mismatches
  task automatic serve_check(input string tag);
    logic [31:0] d, e;
    bus_read(A_SRC, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
    check_eq(tag, d, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; addr_i = '0; data_i = '0; rden_i = 1'b0; wren_i = 1'b0; xirq_i = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t1_ack", {31'b0, ack_o}, 32'd0);
    check_eq("t1_data", data_o, 32'd0);
    check_eq("t1_irq", {31'b0, cpu_irq_o}, 32'd0);
    rst_i = 1'b0;
    read_check("t1_en",    A_EN,    32'h0);
    read_check("t1_pend",  A_PEND,  32'h0);
    read_check("t1_src",   A_SRC,   32'h0);
    read_check("t1_ttype", A_TTYPE, 32'hA5);
    read_check("t1_tpol",  A_TPOL,  32'h0F);
    read_check("t1_ctrl",  A_CTRL,  32'h0);
    @(negedge clk);
    check_eq("t1_idle_data", data_o, 32'd0);

    // T2 level-high ch3
    bus_write(A_TTYPE, 32'h0);
    bus_write(A_TPOL, 32'h8);
    bus_write(A_EN, 32'h8);
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    xirq_i[3] = 1'b1;
    exp_q.push_back(32'h80000003);
    wait_irq("t2_irq1", cyc);
    check_eq("t2_latency", 32'(cyc), 32'd5);
    serve_check("t2_src1");
    exp_q.push_back(32'h80000003);
    bus_write(A_SRC, 32'h0);
    wait_irq("t2_irq2", cyc);
    serve_check("t2_src2");
    bus_write(A_EN, 32'h0);
    bus_write(A_SRC, 32'h0);
    bus_write(A_CTRL, 32'h0);
    xirq_i = '0;
    read_check("t2_pend_clr", A_PEND, 32'h0);

    // T3 simultaneous rising edges, fixed priority
    repeat (4) @(negedge clk);
    bus_write(A_TTYPE, 32'h21);
    bus_write(A_TPOL, 32'h21);
    bus_write(A_PEND, 32'hFF);
    bus_write(A_EN, 32'h21);
    bus_write(A_CTRL, 32'h1);
    exp_q.push_back(32'h80000000);
    exp_q.push_back(32'h80000005);
    @(negedge clk);
    xirq_i = 32'h21;
    wait_irq("t3_irq1", cyc);
    read_check("t3_pend1", A_PEND, 32'h21);
    serve_check("t3_src1");
    bus_write(A_SRC, 32'h0);
    wait_irq("t3_irq2", cyc);
    read_check("t3_pend2", A_PEND, 32'h20);
    serve_check("t3_src2");
    bus_write(A_SRC, 32'h0);
    read_check("t3_pend3", A_PEND, 32'h0);
    read_check("t3_src_idle", A_SRC, 32'h5);

    // T4 round-robin over two held level lines
    bus_write(A_EN, 32'h0);
    bus_write(A_CTRL, 32'h0);
    xirq_i = '0;
    repeat (4) @(negedge clk);
    bus_write(A_TTYPE, 32'h0);
    bus_write(A_TPOL, 32'h6);
    bus_write(A_PEND, 32'hFF);
    bus_write(A_EN, 32'h6);
    bus_write(A_CTRL, 32'h3);
    exp_q.push_back(32'h80000001);
    exp_q.push_back(32'h80000002);
    exp_q.push_back(32'h80000001);
    exp_q.push_back(32'h80000002);
    @(negedge clk);
    xirq_i = 32'h6;
    for (int n = 0; n < 3; n++) begin
      wait_irq("t4_irq", cyc);
      serve_check("t4_src");
      bus_write(A_SRC, 32'h0);
    end
    wait_irq("t4_irq4", cyc);
    serve_check("t4_src4");
    bus_write(A_CTRL, 32'h0);
    bus_write(A_EN, 32'h0);
    bus_write(A_SRC, 32'h0);
    bus_write(A_PEND, 32'hFF);
    xirq_i = '0;
    read_check("t4_pend", A_PEND, 32'h0);

    // T5 set beats same-cycle W1C; idle complete ignored; bus corners
    repeat (4) @(negedge clk);
    bus_write(A_TTYPE, 32'h4);
    bus_write(A_TPOL, 32'h4);
    repeat (4) @(negedge clk);
    bus_write(A_PEND, 32'hFF);
    bus_write(A_EN, 32'h4);
    read_check("t5_pend0", A_PEND, 32'h0);
    @(negedge clk);
    xirq_i[2] = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(A_PEND, 32'h4);
    read_check("t5_set_wins", A_PEND, 32'h4);
    bus_write(A_SRC, 32'h0);
    read_check("t5_idle_complete", A_PEND, 32'h4);
    bus_write(A_PEND, 32'h4);
    read_check("t5_w1c", A_PEND, 32'h0);
    read_check("t5_unmapped", A_UNM, 32'h0);
    @(negedge clk);
    addr_i = 32'h00000008; rden_i = 1'b1;
    @(negedge clk);
    rden_i = 1'b0;
    check_eq("t5_oow_ack", {31'b0, ack_o}, 32'd0);
    bus_write(A_EN, 32'hFFFFFFFF);
    read_check("t5_en_mask", A_EN, 32'hFF);
    bus_write(A_EN, 32'h0);
    bus_write(A_PEND, 32'hFF);

    // T6 reset while ACTIVE
    bus_write(A_TTYPE, 32'h0);
    bus_write(A_EN, 32'h4);
    bus_write(A_CTRL, 32'h1);
    wait_irq("t6_irq", cyc);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("t6_irq_low", {31'b0, cpu_irq_o}, 32'd0);
    read_check("t6_pend", A_PEND, 32'h0);
    bus_read(A_SRC, v);
    check_eq("t6_src_valid", {31'b0, v[31]}, 32'd0);
    read_check("t6_ctrl", A_CTRL, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
